// File: rtl/stereo_pkg.sv
// Shared stereo-pipeline constants used by the SAD accumulator and the winner-take-all stage.
package stereo_pkg;

  localparam int unsigned DIFF_BITS    = 8;
  localparam int unsigned SAD_WIN_LEN  = 9;
  localparam int unsigned SAD_SUM_BITS = 12;

  // Running-sum width that holds win_len * (2^diff_bits - 1) without overflow.
  function automatic int unsigned sad_acc_bits(input int unsigned diff_bits,
                                               input int unsigned win_len);
    return diff_bits + $clog2(win_len) + 1;
  endfunction

endpackage

// File: rtl/sad_delay_line.sv
// Window history for the SAD accumulator: shift register with enable and synchronous clear.
// Clear and enable together load din as the only non-zero entry (new row, first sample).
module sad_delay_line #(
  parameter int unsigned num_bits = 8,
  parameter int unsigned WIN_LEN  = 9
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic                enable,
  input  logic [num_bits-1:0] din,
  output logic [num_bits-1:0] oldest
);

  logic [num_bits-1:0] taps_q [WIN_LEN];
  logic [num_bits-1:0] taps_d [WIN_LEN];

  always_comb begin
    for (int i = 0; i < WIN_LEN; i++) begin
      taps_d[i] = clear ? '0 : taps_q[i];
    end
    if (enable) begin
      taps_d[0] = din;
      for (int i = 1; i < WIN_LEN; i++) begin
        taps_d[i] = clear ? '0 : taps_q[i-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < WIN_LEN; i++) begin
      if (reset) begin
        taps_q[i] <= '0;
      end else begin
        taps_q[i] <= taps_d[i];
      end
    end
  end

  assign oldest = taps_q[WIN_LEN-1];

endmodule

// File: rtl/sad_window_accumulator.sv
// Sliding-window SAD over the last WIN_LEN accepted samples of a row.
// Define SAD_SATURATE_EN to clamp out_sum to all ones instead of truncating.
module sad_window_accumulator
  import stereo_pkg::*;
#(
  parameter int unsigned num_bits = DIFF_BITS,
  parameter int unsigned WIN_LEN  = SAD_WIN_LEN,
  parameter int unsigned ACC_BITS = sad_acc_bits(num_bits, WIN_LEN),
  parameter int unsigned SUM_BITS = SAD_SUM_BITS,
  localparam int unsigned FillBits = $clog2(WIN_LEN + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [num_bits-1:0] in_diff,
  input  logic                line_start,
  output logic                out_valid,
  output logic [SUM_BITS-1:0] out_sum,
  output logic [FillBits-1:0] fill_count
);

  localparam logic [FillBits-1:0] FillMax = FillBits'(WIN_LEN);

  logic [ACC_BITS-1:0] sum_q, sum_d, sum_base, oldest_ext;
  logic [FillBits-1:0] fill_q, fill_d, fill_base;
  logic [SUM_BITS-1:0] out_sum_q, out_sum_d;
  logic                out_valid_q, out_valid_d;
  logic [num_bits-1:0] tap_oldest;

  sad_delay_line #(
    .num_bits (num_bits),
    .WIN_LEN  (WIN_LEN)
  ) u_delay_line (
    .clock  (clock),
    .reset  (reset),
    .clear  (line_start),
    .enable (in_valid),
    .din    (in_diff),
    .oldest (tap_oldest)
  );

  function automatic logic [SUM_BITS-1:0] fit_sum(input logic [ACC_BITS-1:0] s);
`ifdef SAD_SATURATE_EN
    // One extra bit so the limit is representable even when SUM_BITS == ACC_BITS.
    logic [ACC_BITS:0] limit;
    limit = (ACC_BITS + 1)'(1) << SUM_BITS;
    return ({1'b0, s} >= limit) ? '1 : s[SUM_BITS-1:0];
`else
    return s[SUM_BITS-1:0];
`endif
  endfunction

  // line_start clears history before any same-cycle sample is accepted.
  always_comb begin
    sum_base   = line_start ? '0 : sum_q;
    fill_base  = line_start ? '0 : fill_q;
    oldest_ext = (!line_start && fill_q == FillMax) ? ACC_BITS'(tap_oldest) : '0;
    sum_d       = sum_base;
    fill_d      = fill_base;
    out_sum_d   = out_sum_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      sum_d       = sum_base + ACC_BITS'(in_diff) - oldest_ext;
      fill_d      = (fill_base == FillMax) ? FillMax : fill_base + 1'b1;
      out_sum_d   = fit_sum(sum_d);
      out_valid_d = (fill_d == FillMax);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sum_q       <= '0;
      fill_q      <= '0;
      out_sum_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      fill_q      <= fill_d;
      out_sum_q   <= out_sum_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sum    = out_sum_q;
  assign fill_count = fill_q;

endmodule

// File: tb/tb_sad_window_accumulator.sv
// Directed self-checking bench for sad_window_accumulator (default build and SAD_SATURATE_EN).
module tb_sad_window_accumulator;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_diff;
  logic        line_start;
  logic        out_valid, out_valid10;
  logic [11:0] out_sum;
  logic [9:0]  out_sum10;
  logic [3:0]  fill_count, fill_count10;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  sad_window_accumulator dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_diff    (in_diff),
    .line_start (line_start),
    .out_valid  (out_valid),
    .out_sum    (out_sum),
    .fill_count (fill_count)
  );

  sad_window_accumulator #(.SUM_BITS(10)) dut10 (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_diff    (in_diff),
    .line_start (line_start),
    .out_valid  (out_valid10),
    .out_sum    (out_sum10),
    .fill_count (fill_count10)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive at the falling edge, then sample 1 time unit after the next rising edge.
  task automatic step(input logic v, input logic [7:0] d, input logic ls, input logic rst);
    @(negedge clock);
    in_valid   = v;
    in_diff    = d;
    line_start = ls;
    reset      = rst;
    @(posedge clock);
    #1;
  endtask

  initial begin
    in_valid = 1'b0; in_diff = '0; line_start = 1'b0; reset = 1'b1;
    step(1'b1, 8'd77, 1'b0, 1'b1);
    step(1'b0, 8'd0, 1'b0, 1'b1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(out_sum), 32'd0);
    check("rst_fill", 32'(fill_count), 32'd0);

    // Nine samples of 10: first full window on the ninth.
    for (int k = 1; k <= 9; k++) begin
      step(1'b1, 8'd10, 1'b0, 1'b0);
      if (k < 9) check($sformatf("fill10_valid_%0d", k), 32'(out_valid), 32'd0);
      check($sformatf("fill10_cnt_%0d", k), 32'(fill_count), 32'(k));
    end
    check("fill10_valid9", 32'(out_valid), 32'd1);
    check("fill10_sum9", 32'(out_sum), 32'd90);

    step(1'b1, 8'd20, 1'b0, 1'b0);
    check("slide20_sum_a", 32'(out_sum), 32'd100);
    check("slide20_valid_a", 32'(out_valid), 32'd1);
    step(1'b1, 8'd20, 1'b0, 1'b0);
    check("slide20_sum_b", 32'(out_sum), 32'd110);
    check("slide20_valid_b", 32'(out_valid), 32'd1);

    // Ramp 1..12 starting a new row.
    step(1'b1, 8'd1, 1'b1, 1'b0);
    check("ramp_fill1", 32'(fill_count), 32'd1);
    check("ramp_valid1", 32'(out_valid), 32'd0);
    check("ramp_sum1", 32'(out_sum), 32'd1);
    for (int k = 2; k <= 12; k++) begin
      step(1'b1, 8'(k), 1'b0, 1'b0);
      if (k < 9) check($sformatf("ramp_valid_%0d", k), 32'(out_valid), 32'd0);
    end
    check("ramp_sum12", 32'(out_sum), 32'd72);
    check("ramp_valid12", 32'(out_valid), 32'd1);

    // Recheck 45/54/63 on a fresh ramp pass.
    step(1'b1, 8'd1, 1'b1, 1'b0);
    for (int k = 2; k <= 11; k++) begin
      step(1'b1, 8'(k), 1'b0, 1'b0);
      if (k == 9)  check("ramp_sum9", 32'(out_sum), 32'd45);
      if (k == 10) check("ramp_sum10", 32'(out_sum), 32'd54);
      if (k == 11) check("ramp_sum11", 32'(out_sum), 32'd63);
    end

    // line_start with a sample mid-row after a full window.
    step(1'b1, 8'd7, 1'b1, 1'b0);
    check("ls_fill", 32'(fill_count), 32'd1);
    check("ls_valid", 32'(out_valid), 32'd0);
    check("ls_sum", 32'(out_sum), 32'd7);
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 8'd1, 1'b0, 1'b0);
      if (k == 7) check("ls_valid_pre", 32'(out_valid), 32'd0);
    end
    check("ls_sum_full", 32'(out_sum), 32'd15);
    check("ls_valid_full", 32'(out_valid), 32'd1);

    step(1'b0, 8'd99, 1'b0, 1'b0);
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_sum_hold", 32'(out_sum), 32'd15);
    check("idle_fill_hold", 32'(fill_count), 32'd9);

    // line_start alone clears history; out_sum holds.
    step(1'b0, 8'd0, 1'b1, 1'b0);
    check("lsonly_fill", 32'(fill_count), 32'd0);
    check("lsonly_valid", 32'(out_valid), 32'd0);
    check("lsonly_sum_hold", 32'(out_sum), 32'd15);

    // 255s every other cycle.
    for (int k = 1; k <= 9; k++) begin
      step(1'b1, 8'd255, 1'b0, 1'b0);
      check($sformatf("gap_sum_%0d", k), 32'(out_sum), 32'(255 * k));
      check($sformatf("gap_valid_%0d", k), 32'(out_valid), (k == 9) ? 32'd1 : 32'd0);
      if (k < 9) begin
        step(1'b0, 8'd0, 1'b0, 1'b0);
        check($sformatf("gap_hold_valid_%0d", k), 32'(out_valid), 32'd0);
        check($sformatf("gap_hold_sum_%0d", k), 32'(out_sum), 32'(255 * k));
      end
    end
    check("gap_fill", 32'(fill_count), 32'd9);
    check("narrow_valid", 32'(out_valid10), 32'd1);
`ifdef SAD_SATURATE_EN
    check("narrow_sum", 32'(out_sum10), 32'd1023);
`else
    check("narrow_sum", 32'(out_sum10), 32'd247);
`endif
    step(1'b0, 8'd0, 1'b0, 1'b0);
    check("gap_tail_valid", 32'(out_valid), 32'd0);
    check("gap_tail_sum", 32'(out_sum), 32'd2295);

    // Reset mid-window drops the same-cycle sample.
    step(1'b1, 8'd3, 1'b1, 1'b0);
    for (int k = 2; k <= 5; k++) step(1'b1, 8'd3, 1'b0, 1'b0);
    check("mid_fill5", 32'(fill_count), 32'd5);
    step(1'b1, 8'd50, 1'b0, 1'b1);
    check("mid_rst_fill", 32'(fill_count), 32'd0);
    check("mid_rst_sum", 32'(out_sum), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    for (int k = 1; k <= 9; k++) begin
      step(1'b1, 8'd2, 1'b0, 1'b0);
      if (k == 8) check("refill_valid8", 32'(out_valid), 32'd0);
    end
    check("refill_valid9", 32'(out_valid), 32'd1);
    check("refill_sum9", 32'(out_sum), 32'd18);

    step(1'b0, 8'd0, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sad_window_accumulator.md
Name: sad_window_accumulator

Overview:
- Downstream of the per-pixel absolute-difference stage in the stereo pipeline.
- Takes one registered |L-R| value per valid cycle and forms a sliding-window sum of absolute differences (SAD) over the last WIN_LEN accepted samples of the current row.
- The SAD feeds the disparity winner-take-all compare stage.
- Window history is held in an internal delay line, so the sum updates in O(1) per sample (add newest, subtract oldest).

Parameters:
- num_bits, 8: width of each incoming absolute difference.
- WIN_LEN, 9: window length in samples; legal range 2..64.
- ACC_BITS, num_bits+$clog2(WIN_LEN)+1: internal running-sum width; must hold WIN_LEN*(2^num_bits-1) without overflow.
- SUM_BITS, 12: width of the out_sum port; must be <= ACC_BITS.

Ports:
- clock  in  1  rising-edge clock, sole clock domain.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  in_diff is valid this cycle.
- in_diff  in  num_bits  absolute difference from the upstream stage.
- line_start  in  1  start of a new image row; clears window history.
- out_valid  out  1  out_sum holds a full-window SAD this cycle.
- out_sum  out  SUM_BITS  windowed SAD.
- fill_count  out  $clog2(WIN_LEN+1)  accepted samples in window, saturating at WIN_LEN.

Behaviour:
- Reset (reset=1 at a rising edge): delay line, running sum, fill_count, out_sum and out_valid all go to 0. Reset overrides every other input, including mid-window, and the in_valid sample on that cycle is dropped.
- Accept rule: a sample is accepted on any edge with in_valid=1 and reset=0. There is no backpressure; upstream never stalls.
- Cycles with in_valid=0: state and out_sum hold, and out_valid goes low.
- On accept:
  - oldest = delay-line tap WIN_LEN-1 if fill_count==WIN_LEN, else 0.
  - sum_next = sum + in_diff - oldest, computed at ACC_BITS, zero-extended, never negative.
  - in_diff is shifted into the delay line.
  - fill_count increments, saturating at WIN_LEN.
- Latency: out_sum and out_valid are registered 1 cycle after the accepting edge.
- out_valid=1 for exactly one cycle per accepted sample whose post-accept fill_count==WIN_LEN. The first valid output is the WIN_LEN-th sample of a row.
- out_sum updates on every accept, including partial windows, but is qualified only by out_valid.
- line_start=1 with in_valid=0: delay line, sum and fill_count clear to 0; out_valid=0; out_sum holds.
- line_start=1 with in_valid=1: clear first, then accept in_diff as sample 1 of the new row. Result: sum=in_diff, fill_count=1, out_valid=0 next cycle.
- Back-to-back valid every cycle: one out_valid per cycle once full. Throughput is 1 sample/clock.
- Without the optional feature, out_sum = sum[SUM_BITS-1:0] (truncation).

Optional Feature:
- Macro: SAD_SATURATE_EN.
- Defined: if sum >= 2^SUM_BITS, out_sum = all ones (SUM_BITS'b1...1); otherwise out_sum = sum. Internal sum is never clamped, so the window stays exact.
- Undefined: truncation as above; no compare logic is synthesized.

Decomposition:
- Shared package stereo_pkg:
  - DIFF_BITS (=8), SAD_WIN_LEN (=9), SAD_SUM_BITS (=12).
  - localparam function for ACC_BITS.
  - These constants are also consumed by the winner-take-all stage.
- One sub-module: sad_delay_line, a WIN_LEN-deep, num_bits-wide shift register with enable and synchronous clear, exposing the oldest tap. Sum, fill and output logic stay in the top module.

Test Plan:
- Reset then 9 valid samples of 10 -> out_valid low for the first 8 output cycles; 9th gives out_valid=1, out_sum=90, fill_count=9.
- Continue with samples 20,20 -> out_sum=100 then 110, out_valid=1 each cycle.
- Ramp 1..12 continuous -> first valid out_sum=45 (1..9), then 54, 63, 72.
- line_start with in_valid and in_diff=7 mid-row after a full window -> fill_count=1, out_valid=0; 8 more samples of 1 give out_sum=15, out_valid=1.
- in_valid gaps (valid every other cycle, 9 samples of 255, SUM_BITS=12) -> out_valid pulses only after accepts; final out_sum=2295; sum held across gaps.
- SUM_BITS=10, 9 samples of 255 -> with SAD_SATURATE_EN out_sum=1023; without it out_sum=2295 mod 1024=247.
- Assert reset mid-window (fill_count=5) -> all outputs 0 next cycle; refill requires 9 new samples.
